// File: rtl/lsu_bus_bridge.sv
// Load/store to word bus bridge: lane steering, load extension,
// alignment checks and bus timeout.
module lsu_bus_bridge #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        mem_write,
   input  logic [3:0]  ls,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        access_err,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int CW = $clog2(TIMEOUT);

   localparam logic [3:0] LS_W  = 4'b0000;
   localparam logic [3:0] LS_H  = 4'b1000;
   localparam logic [3:0] LS_B  = 4'b0100;
   localparam logic [3:0] LS_HU = 4'b0010;
   localparam logic [3:0] LS_BU = 4'b0001;

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d, cnt_inc;
   logic          wr_q, wr_d;
   logic [3:0]    ls_q, ls_d;
   logic [1:0]    lo_q, lo_d;

   logic          req_d, we_d, done_d, aerr_d, berr_d;
   logic [31:0]   addr_d, wd_d, rdata_d;
   logic [3:0]    be_d;

   logic          bad;
   logic [3:0]    be_calc;
   logic [31:0]   wd_calc;

   function automatic logic [31:0] fmt(
      input logic [3:0]  l,
      input logic [1:0]  lo,
      input logic [31:0] w
   );
      logic [7:0]  b8;
      logic [15:0] h16;
      b8  = w[{lo, 3'b000} +: 8];
      h16 = lo[1] ? w[31:16] : w[15:0];
      unique case (l)
         LS_B:    fmt = {{24{b8[7]}}, b8};
         LS_BU:   fmt = {24'b0, b8};
         LS_H:    fmt = {{16{h16[15]}}, h16};
         LS_HU:   fmt = {16'b0, h16};
         default: fmt = w;
      endcase
   endfunction

   // Legality, byte enables and lane replication for the incoming request
   always_comb begin
      bad     = 1'b0;
      be_calc = 4'b0000;
      wd_calc = wdata;
      unique case (ls)
         LS_W: begin
            bad     = addr[1:0] != 2'b00;
            be_calc = 4'b1111;
         end
         LS_H, LS_HU: begin
            bad     = addr[0] | (mem_write & (ls == LS_HU));
            be_calc = addr[1] ? 4'b1100 : 4'b0011;
            wd_calc = {2{wdata[15:0]}};
         end
         LS_B, LS_BU: begin
            bad     = mem_write & (ls == LS_BU);
            be_calc = 4'b0001 << addr[1:0];
            wd_calc = {4{wdata[7:0]}};
         end
         default: bad = 1'b1;
      endcase
   end

   assign cnt_inc = cnt + CW'(1);
   assign stall   = ((state == IDLE) & req_valid) | (state == BUS);

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      wr_d    = wr_q;
      ls_d    = ls_q;
      lo_d    = lo_q;
      req_d   = 1'b0;
      we_d    = 1'b0;
      addr_d  = 32'b0;
      be_d    = 4'b0;
      wd_d    = 32'b0;
      done_d  = 1'b0;
      rdata_d = 32'b0;
      aerr_d  = 1'b0;
      berr_d  = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_d = '0;
            if (req_valid && bad) begin
               state_d = RESP;
               done_d  = 1'b1;
               aerr_d  = 1'b1;
            end else if (req_valid) begin
               state_d = BUS;
               wr_d    = mem_write;
               ls_d    = ls;
               lo_d    = addr[1:0];
               req_d   = 1'b1;
               we_d    = mem_write;
               addr_d  = {addr[31:2], 2'b00};
               be_d    = be_calc;
               wd_d    = mem_write ? wd_calc : 32'b0;
            end
         end
         BUS: begin
            cnt_d = cnt_inc;
            if (bus_ack) begin
               state_d = RESP;
               done_d  = 1'b1;
               rdata_d = wr_q ? 32'b0 : fmt(ls_q, lo_q, bus_rdata);
            end else if (cnt_inc == CW'(TIMEOUT - 1)) begin
               state_d = RESP;
               done_d  = 1'b1;
               berr_d  = 1'b1;
            end else begin
               req_d  = 1'b1;
               we_d   = bus_we;
               addr_d = bus_addr;
               be_d   = bus_be;
               wd_d   = bus_wdata;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         wr_q       <= 1'b0;
         ls_q       <= 4'b0;
         lo_q       <= 2'b0;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= 32'b0;
         bus_be     <= 4'b0;
         bus_wdata  <= 32'b0;
         done       <= 1'b0;
         rdata      <= 32'b0;
         access_err <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         wr_q       <= wr_d;
         ls_q       <= ls_d;
         lo_q       <= lo_d;
         bus_req    <= req_d;
         bus_we     <= we_d;
         bus_addr   <= addr_d;
         bus_be     <= be_d;
         bus_wdata  <= wd_d;
         done       <= done_d;
         rdata      <= rdata_d;
         access_err <= aerr_d;
         bus_err    <= berr_d;
      end
   end

endmodule
